// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked integer ALU with iterative multiply and optional divide
// Optional divider (divu/remu) is built only when SEQ_ALU_DIV_EN is defined.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_SHL  = 4'b0011;
  localparam logic [3:0] OP_SHR  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   x_q, x_d;      // multiplicand / dividend-quotient shifter
  logic [WIDTH-1:0]   y_q, y_d;      // multiplier / divisor
  logic [WIDTH-1:0]   acc_q, acc_d;  // product / partial remainder
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               dbz_q, dbz_d;
  logic               ill_q, ill_d;

  logic [WIDTH-1:0]   quick_res;
  logic               quick_ill;
  logic               big_shift;
  logic [WIDTH-1:0]   mul_acc_nx;

  // Results of the single-cycle opcodes, computed straight from the inputs at accept.
  always_comb begin
    quick_res = '0;
    quick_ill = 1'b0;
    big_shift = (b >= WIDTH_V);
    case (alu_op)
      OP_ADD:  quick_res = a + b;
      OP_SUB:  quick_res = a - b;
      OP_SHL:  quick_res = big_shift ? '0 : (a << b[SHW-1:0]);
      OP_SHR:  quick_res = big_shift ? '0 : (a >> b[SHW-1:0]);
      OP_SRA:  quick_res = big_shift ? {WIDTH{a[WIDTH-1]}}
                                     : WIDTH'($signed(a) >>> b[SHW-1:0]);
      OP_SLTU: quick_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLT:  quick_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MUL:  quick_res = '0;
      default: quick_ill = 1'b1;
    endcase
  end

  assign mul_acc_nx = acc_q + (y_q[0] ? x_q : '0);

`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_nx, quo_nx;

  // Restoring step: shift in the next dividend bit, keep the difference if non-negative.
  always_comb begin
    rem_sh   = {acc_q, x_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, y_q};
    div_ge   = ~rem_diff[WIDTH];
    rem_nx   = div_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx   = {x_q[WIDTH-2:0], div_ge};
  end
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    x_d       = x_q;
    y_d       = y_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    dbz_d     = dbz_q;
    ill_d     = ill_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d  = alu_op;
          dbz_d = 1'b0;
          ill_d = 1'b0;
          if (alu_op == OP_MUL) begin
            x_d     = a;
            y_d     = b;
            acc_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
            state_d = S_BUSY;
`ifdef SEQ_ALU_DIV_EN
          end else if (alu_op == OP_DIVU || alu_op == OP_REMU) begin
            if (b == '0) begin
              result_d = (alu_op == OP_REMU) ? a : '1;
              dbz_d    = 1'b1;
              state_d  = S_DONE;
            end else begin
              x_d     = a;
              y_d     = b;
              acc_d   = '0;
              cnt_d   = CNT_W'(WIDTH);
              state_d = S_BUSY;
            end
`endif
          end else begin
            result_d = quick_res;
            ill_d    = quick_ill;
            state_d  = S_DONE;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (op_q == OP_MUL) begin
          acc_d = mul_acc_nx;
          x_d   = x_q << 1;
          y_d   = y_q >> 1;
          if (cnt_q == CNT_W'(1)) begin
            result_d = mul_acc_nx;
            state_d  = S_DONE;
          end
`ifdef SEQ_ALU_DIV_EN
        end else begin
          acc_d = rem_nx;
          x_d   = quo_nx;
          if (cnt_q == CNT_W'(1)) begin
            result_d = (op_q == OP_REMU) ? rem_nx : quo_nx;
            state_d  = S_DONE;
          end
`endif
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
      ill_q    <= ill_d;
    end
  end

  assign result     = result_q;
  assign zero       = (state_q == S_DONE) && (result_q == '0);
  assign illegal_op = ill_q;
`ifdef SEQ_ALU_DIV_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule
